cache_flush_walker: RTL and testbench

// Reader/consumer side of the per-set valid and dirty bit arrays. On a flush request it walks every set
// of a direct-mapped cache and writes each valid+dirty line back to physical memory over the pmem

---
 rtl/cache_flush_pkg.sv | 32 +++
 rtl/flush_wb_buffer.sv | 34 +++
 rtl/cache_flush_walker.sv | 123 ++++++++++++
 tb/tb_cache_flush_walker.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_flush_pkg.sv
// cache_flush_pkg
// Shared widths, FSM state encoding and the writeback address helper for
// the cache flush walker.
//   S_OFFSET / S_INDEX / S_TAG / S_LINE : cache geometry (tag+index+offset = 32)
//   NUM_SETS                            : number of sets walked per flush
//   LAST_IDX                            : index of the final set
//   flush_state_t                       : walker FSM states
//   make_wb_addr(tag, idx)              : line-aligned physical writeback address
package cache_flush_pkg;

    localparam int S_OFFSET = 5;
    localparam int S_INDEX  = 3;
    localparam int S_TAG    = 24;
    localparam int S_LINE   = 256;
    localparam int NUM_SETS = 1 << S_INDEX;

    localparam logic [S_INDEX-1:0] LAST_IDX = S_INDEX'(NUM_SETS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SCAN      = 3'd1,
        ST_WRITEBACK = 3'd2,
        ST_CLEAR     = 3'd3,
        ST_DONE      = 3'd4
    } flush_state_t;

    function automatic logic [31:0] make_wb_addr(input logic [S_TAG-1:0]   tag,
                                                 input logic [S_INDEX-1:0] idx);
        return {tag, idx, {S_OFFSET{1'b0}}};
    endfunction

endpackage

// File: rtl/flush_wb_buffer.sv
// flush_wb_buffer
// Captures the tag and data line of the set being written back so the pmem
// request stays stable while the walker holds pmem_write.
//   clk, rst  : clock, synchronous active-high reset (clears the buffer)
//   load      : capture tag_d / line_d this cycle
//   clr       : zero the buffer (load is ignored when clr is set)
//   tag_d     : tag from the array read port
//   line_d    : data line from the array read port
//   tag_q     : captured tag
//   line_q    : captured line
module flush_wb_buffer
    import cache_flush_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clr,
    input  logic [S_TAG-1:0]  tag_d,
    input  logic [S_LINE-1:0] line_d,
    output logic [S_TAG-1:0]  tag_q,
    output logic [S_LINE-1:0] line_q
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            tag_q  <= '0;
            line_q <= '0;
        end else if (load) begin
            tag_q  <= tag_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/cache_flush_walker.sv
// cache_flush_walker
// Walks every set of a direct-mapped cache on a flush request, writes each
// valid+dirty line back over the pmem handshake and invalidates every set.
//   clk, rst                 : clock, synchronous active-high reset
//   flush_req                : start a walk (only looked at in IDLE)
//   busy, flush_done         : walk in progress / one-cycle completion pulse
//   arr_rindex, arr_windex   : array read / write index (both the walk index)
//   valid_in, dirty_in,
//   tag_in, line_in          : combinational array read data at arr_rindex
//   valid_load, dirty_load   : invalidate strobes, write data arr_datain (=0)
//   pmem_address, pmem_wdata,
//   pmem_write, pmem_resp    : writeback request, held until pmem_resp
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for flush_req
// SCAN       | inspect set idx; clean/invalid sets are invalidated here
// WRITEBACK  | pmem_write held with latched tag/line until pmem_resp
// CLEAR      | invalidate set idx after its writeback
// DONE       | flush_done pulse, back to IDLE
module cache_flush_walker
    import cache_flush_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_req,
    output logic               busy,
    output logic               flush_done,
    output logic [S_INDEX-1:0] arr_rindex,
    input  logic               valid_in,
    input  logic               dirty_in,
    input  logic [S_TAG-1:0]   tag_in,
    input  logic [S_LINE-1:0]  line_in,
    output logic [S_INDEX-1:0] arr_windex,
    output logic               valid_load,
    output logic               dirty_load,
    output logic               arr_datain,
    output logic [31:0]        pmem_address,
    output logic [S_LINE-1:0]  pmem_wdata,
    output logic               pmem_write,
    input  logic               pmem_resp
);

    flush_state_t       state;
    logic [S_INDEX-1:0] idx;
    logic               needs_wb;
    logic               last_set;
    logic               clear_set;
    logic [S_TAG-1:0]   tag_q;
    logic [S_LINE-1:0]  line_q;

    assign needs_wb = valid_in & dirty_in;
    assign last_set = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            idx   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (flush_req) begin
                        idx   <= '0;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (needs_wb) begin
                        state <= ST_WRITEBACK;
                    end else if (last_set) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_WRITEBACK: begin
                    if (pmem_resp) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (last_set) begin
                        state <= ST_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_SCAN;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    flush_wb_buffer u_wb_buffer (
        .clk    (clk),
        .rst    (rst),
        .load   ((state == ST_SCAN) && needs_wb),
        .clr    (state == ST_DONE),
        .tag_d  (tag_in),
        .line_d (line_in),
        .tag_q  (tag_q),
        .line_q (line_q)
    );

    // Clean or invalid sets are invalidated in the same SCAN cycle they are
    // read; the array's write bypass makes that read/write overlap safe.
    assign clear_set = ((state == ST_SCAN) && !needs_wb) || (state == ST_CLEAR);

    assign busy       = (state != ST_IDLE);
    assign flush_done = (state == ST_DONE);
    assign arr_rindex = idx;
    assign arr_windex = idx;
    assign valid_load = clear_set;
    assign dirty_load = clear_set;
    assign arr_datain = 1'b0;

    // The pmem bus is driven only while a writeback is outstanding.
    assign pmem_write   = (state == ST_WRITEBACK);
    assign pmem_address = pmem_write ? make_wb_addr(tag_q, idx) : 32'd0;
    assign pmem_wdata   = pmem_write ? line_q : '0;

endmodule

// File: tb/tb_cache_flush_walker.sv
module tb_cache_flush_walker;
    import cache_flush_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               flush_req = 1'b0;
    logic               busy, flush_done;
    logic [2:0]         arr_rindex, arr_windex;
    logic               valid_in, dirty_in;
    logic [23:0]        tag_in;
    logic [255:0]       line_in;
    logic               valid_load, dirty_load, arr_datain;
    logic [31:0]        pmem_address;
    logic [255:0]       pmem_wdata;
    logic               pmem_write, pmem_resp;
    logic               resp_auto = 1'b0, resp_stray = 1'b0;

    always #5 clk = ~clk;
    assign pmem_resp = resp_auto | resp_stray;

    cache_flush_walker dut (
        .clk(clk), .rst(rst), .flush_req(flush_req), .busy(busy), .flush_done(flush_done),
        .arr_rindex(arr_rindex), .valid_in(valid_in), .dirty_in(dirty_in), .tag_in(tag_in),
        .line_in(line_in), .arr_windex(arr_windex), .valid_load(valid_load),
        .dirty_load(dirty_load), .arr_datain(arr_datain), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
    );

    // cache array model: combinational read, clear on strobes
    logic         mv [8];
    logic         md [8];
    logic [23:0]  mt [8];
    logic [255:0] ml [8];
    logic         iv [8];
    logic         id [8];
    logic [23:0]  it [8];
    logic [255:0] il [8];
    logic         init_req = 1'b0;

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < 8; i++) begin
                mv[i] <= iv[i]; md[i] <= id[i]; mt[i] <= it[i]; ml[i] <= il[i];
            end
        end else begin
            if (valid_load) mv[arr_windex] <= 1'b0;
            if (dirty_load) md[arr_windex] <= 1'b0;
        end
    end
    assign valid_in = mv[arr_rindex];
    assign dirty_in = md[arr_rindex];
    assign tag_in   = mt[arr_rindex];
    assign line_in  = ml[arr_rindex];

    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // memory responder: pmem_resp on the resp_delay-th cycle of pmem_write
    int resp_delay = 1;
    int wcnt = 0;
    always @(negedge clk) begin
        if (pmem_write) begin
            wcnt = wcnt + 1;
            resp_auto = (wcnt == resp_delay);
        end else begin
            wcnt = 0;
            resp_auto = 1'b0;
        end
    end

    // scoreboard
    localparam int EV_WB = 0, EV_CLR = 1, EV_DONE = 2;
    typedef struct {
        int           kind;
        int           idx;
        logic [31:0]  addr;
        logic [255:0] data;
        int           lat;
    } ev_t;
    ev_t exp_q[$];

    task automatic push_ev(input int kind, input int idx, input logic [31:0] addr,
                           input logic [255:0] data, input int lat);
        ev_t e;
        e.kind = kind; e.idx = idx; e.addr = addr; e.data = data; e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input int kind, input int idx, input logic [31:0] addr,
                             input logic [255:0] data, input int lat);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event actual=kind%0d/idx%0d required=no_event", kind, idx);
        end else begin
            e = exp_q.pop_front();
            check("event_kind", 256'(kind), 256'(e.kind));
            check("event_idx", 256'(idx), 256'(e.idx));
            if (kind == EV_WB && e.kind == EV_WB) begin
                check("wb_address", 256'(addr), 256'(e.addr));
                check("wb_wdata", data, e.data);
            end
            if (kind == EV_DONE && e.kind == EV_DONE) check("done_latency", 256'(lat), 256'(e.lat));
        end
    endtask

    logic         prev_pw = 1'b0, prev_busy = 1'b0;
    logic [31:0]  prev_addr = '0;
    logic [255:0] prev_wdata = '0;
    logic [31:0]  last_wb_addr = '0;
    logic [255:0] last_wb_data = '0;
    int           bcnt = 0, pw_cycles = 0, done_cnt = 0;

    always @(negedge clk) begin
        if (!rst) begin
            bcnt = busy ? (prev_busy ? bcnt + 1 : 1) : 0;
            if (pmem_write && !prev_pw) begin
                last_wb_addr = pmem_address;
                last_wb_data = pmem_wdata;
                expect_ev(EV_WB, int'(arr_rindex), pmem_address, pmem_wdata, 0);
            end
            if (pmem_write && prev_pw) begin
                check("wb_address_hold", 256'(pmem_address), 256'(prev_addr));
                check("wb_wdata_hold", pmem_wdata, prev_wdata);
            end
            if (pmem_write) pw_cycles++;
            if (valid_load || dirty_load) begin
                check("dirty_load_eq_valid_load", 256'(dirty_load), 256'(valid_load));
                check("arr_datain_zero", 256'(arr_datain), 256'd0);
                check("windex_eq_rindex", 256'(arr_windex), 256'(arr_rindex));
                expect_ev(EV_CLR, int'(arr_windex), 32'd0, '0, 0);
            end
            if (flush_done) begin
                done_cnt++;
                expect_ev(EV_DONE, 0, 32'd0, '0, bcnt);
            end
        end
        prev_pw    = pmem_write && !rst;
        prev_busy  = busy && !rst;
        prev_addr  = pmem_address;
        prev_wdata = pmem_wdata;
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 256'(busy), 256'd0);
        check({tag, "_flush_done"}, 256'(flush_done), 256'd0);
        check({tag, "_pmem_write"}, 256'(pmem_write), 256'd0);
        check({tag, "_loads"}, 256'({valid_load, dirty_load}), 256'd0);
        check({tag, "_pmem_address"}, 256'(pmem_address), 256'd0);
        check({tag, "_pmem_wdata"}, pmem_wdata, 256'd0);
        check({tag, "_arr_index"}, 256'({arr_rindex, arr_windex, arr_datain}), 256'd0);
    endtask

    task automatic load_arrays();
        @(negedge clk) init_req = 1'b1;
        @(negedge clk) init_req = 1'b0;
    endtask

    task automatic clear_init();
        for (int i = 0; i < 8; i++) begin
            iv[i] = 1'b0; id[i] = 1'b0; it[i] = '0; il[i] = '0;
        end
    endtask

    // expected event stream for a complete walk of the loaded contents
    task automatic push_walk(input int lat);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] ix;
            ix = i[2:0];
            if (iv[i] && id[i]) push_ev(EV_WB, i, {it[i], ix, 5'b0}, il[i], 0);
            push_ev(EV_CLR, i, 32'd0, '0, 0);
        end
        push_ev(EV_DONE, 0, 32'd0, '0, lat);
    endtask

    task automatic run_flush(input string nm, input int pw_exp, input bit repulse);
        int n;
        int d0;
        n = 0;
        d0 = done_cnt;
        pw_cycles = 0;
        @(negedge clk) flush_req = 1'b1;
        do begin
            @(negedge clk);
            n++;
            flush_req = repulse && (n == 3 || n == 4);
        end while (!flush_done && n < 400);
        flush_req = 1'b0;
        if (!flush_done) begin
            checks++; failures++;
            $display("FAIL %s_done_timeout actual=no_flush_done required=flush_done", nm);
        end
        repeat (4) @(negedge clk);
        check({nm, "_queue_drained"}, 256'(exp_q.size()), 256'd0);
        check({nm, "_pmem_write_cycles"}, 256'(pw_cycles), 256'(pw_exp));
        check({nm, "_done_pulses"}, 256'(done_cnt - d0), 256'd1);
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(mv[i]) + int'(md[i]);
        check({nm, "_sets_left_valid_or_dirty"}, 256'(n), 256'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clear_init();
        load_arrays();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: all invalid (dirty bits set but not valid), 9-cycle walk
        clear_init();
        for (int i = 0; i < 8; i++) id[i] = 1'b1;
        load_arrays();
        push_walk(9);
        run_flush("all_invalid", 0, 1'b0);

        // 2: set 5 dirty, memory responds on third write cycle
        clear_init();
        iv[5] = 1'b1; id[5] = 1'b1; it[5] = 24'hABCDEF; il[5] = {32{8'hA5}};
        iv[6] = 1'b1; it[6] = 24'h123456; il[6] = {32{8'h3C}};
        load_arrays();
        resp_delay = 3;
        push_walk(13);
        run_flush("set5_dirty", 3, 1'b0);
        check("set5_addr_literal", 256'(last_wb_addr), 256'(32'hABCDEFA0));
        check("set5_wdata_literal", last_wb_data, {32{8'hA5}});

        // 3: every set dirty, single-cycle responses: 8 * 3 + 1 cycles
        clear_init();
        for (int i = 0; i < 8; i++) begin
            iv[i] = 1'b1; id[i] = 1'b1;
            it[i] = 24'h100000 | 24'(i);
            il[i] = {8{32'hC0DE0000 | 32'(i)}};
        end
        load_arrays();
        resp_delay = 1;
        push_walk(25);
        run_flush("all_dirty", 8, 1'b0);

        // 4: set 2 valid clean, set 6 dirty-only; no writeback at all
        clear_init();
        iv[2] = 1'b1; it[2] = 24'hFFFFFF; il[2] = '1;
        id[6] = 1'b1;
        load_arrays();
        push_walk(9);
        run_flush("set2_clean", 0, 1'b0);

        // 5: reset during the writeback of set 3
        clear_init();
        for (int i = 0; i < 8; i++) begin
            iv[i] = 1'b1; id[i] = 1'b1;
            it[i] = 24'h00F000 | 24'(i);
            il[i] = {16{16'h5A00 | 16'(i)}};
        end
        load_arrays();
        resp_delay = 4;
        for (int i = 0; i < 4; i++) begin
            logic [2:0] ix;
            ix = i[2:0];
            push_ev(EV_WB, i, {it[i], ix, 5'b0}, il[i], 0);
            if (i < 3) push_ev(EV_CLR, i, 32'd0, '0, 0);
        end
        @(negedge clk) flush_req = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            flush_req = 1'b0;
            n++;
        end while (!(pmem_write && arr_rindex == 3'd3) && n < 200);
        check("reached_wb_set3", 256'(pmem_write && arr_rindex == 3'd3), 256'd1);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midflush_reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midflush_queue_drained", 256'(exp_q.size()), 256'd0);
        check("midflush_busy_stays_low", 256'(busy), 256'd0);
        n = 0;
        for (int i = 0; i < 3; i++) n += int'(mv[i]);
        check("midflush_sets0to2_cleared", 256'(n), 256'd0);
        n = 0;
        for (int i = 3; i < 8; i++) n += int'(mv[i]) + int'(md[i]);
        check("midflush_sets3to7_kept", 256'(n), 256'd10);
        exp_q.delete();

        // 6: flush_req while busy ignored; pmem_resp in IDLE ignored
        clear_init();
        load_arrays();
        resp_delay = 1;
        push_walk(9);
        run_flush("busy_req_ignored", 0, 1'b1);
        @(negedge clk) resp_stray = 1'b1;
        @(negedge clk) resp_stray = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_resp_busy", 256'(busy), 256'd0);
        check("idle_resp_pmem_write", 256'(pmem_write), 256'd0);
        check("idle_resp_no_events", 256'(exp_q.size()), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
